// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// The half-period field H yields a full output period of 2*(H+1) system clocks.
package clk_div_pkg;

   localparam int CLK_DIV_CNT_W    = 16;
   localparam int CLK_DIV_DEF_HALF = 24;

   // Map a desired even output period to its half-period field; periods below 2 clamp to divide-by-2.
   function automatic logic [CLK_DIV_CNT_W-1:0] half_from_period(input int unsigned period);
      int unsigned h;
      h = (period < 32'd2) ? 32'd0 : (period / 32'd2) - 32'd1;
      return h[CLK_DIV_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, active/pending ratio registers,
// and the toggle/apply rules that keep every full period on a single ratio.
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int CNT_W    = CLK_DIV_CNT_W,
   parameter int DEF_HALF = CLK_DIV_DEF_HALF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] half_in,
   output logic             div_clk,
   output logic             tick,
   output logic             pend
);

   localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HALF);
   localparam logic [CNT_W-1:0] ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] act_q, act_d;
   logic [CNT_W-1:0] pen_q, pen_d;
   logic             div_q, div_d;
   logic             tick_q, tick_d;
   logic             pend_q, pend_d;
   logic             at_end_s;
   logic             apply_s;

   assign at_end_s = (cnt_q == act_q);
   // A new ratio may take effect while idle or on the edge that closes a full period (1->0).
   assign apply_s  = !en || (at_end_s && div_q);

   // Next-state logic for counter, output phase and ratio registers.
   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      tick_d = 1'b0;
      act_d  = act_q;
      pen_d  = pen_q;
      pend_d = pend_q;

      if (!en) begin
         cnt_d = ZERO;
         div_d = 1'b0;
      end else if (at_end_s) begin
         cnt_d  = ZERO;
         div_d  = ~div_q;
         tick_d = ~div_q;
      end else begin
         cnt_d = cnt_q + ONE;
      end

      if (load && apply_s) begin
         act_d  = half_in;
         pen_d  = half_in;
         pend_d = 1'b0;
      end else if (load) begin
         pen_d  = half_in;
         pend_d = 1'b1;
      end else if (pend_q && apply_s) begin
         act_d  = pen_q;
         pend_d = 1'b0;
      end else begin
         pend_d = pend_q;
      end
   end

   // State registers with synchronous reset to the default ratio.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= ZERO;
         act_q  <= DEF_H;
         pen_q  <= DEF_H;
         div_q  <= 1'b0;
         tick_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         act_q  <= act_d;
         pen_q  <= pen_d;
         div_q  <= div_d;
         tick_q <= tick_d;
         pend_q <= pend_d;
      end
   end

   assign div_clk = div_q;
   assign tick    = tick_q;
   assign pend    = pend_q;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: NUM_CH independent channels,
// each fed its own CNT_W-bit slice of half_in.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int CNT_W    = CLK_DIV_CNT_W,
   parameter int DEF_HALF = CLK_DIV_DEF_HALF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH-1:0]       load,
   input  logic [NUM_CH*CNT_W-1:0] half_in,
   output logic [NUM_CH-1:0]       div_clk,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       pend
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_ch #(
         .CNT_W    (CNT_W),
         .DEF_HALF (DEF_HALF)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .en      (en[i]),
         .load    (load[i]),
         .half_in (half_in[i*CNT_W +: CNT_W]),
         .div_clk (div_clk[i]),
         .tick    (tick[i]),
         .pend    (pend[i])
      );
   end

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed vector table, corner-case sequences and a
// randomized run, all checked each cycle against a period-position reference model.
module tb_clk_div_prog;
   import clk_div_pkg::*;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 16;
   localparam int DEF    = 24;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_CH-1:0]       en;
   logic [NUM_CH-1:0]       load;
   logic [NUM_CH*CNT_W-1:0] half_in;
   logic [NUM_CH-1:0]       div_clk;
   logic [NUM_CH-1:0]       tick;
   logic [NUM_CH-1:0]       pend;

   always #5 clk = ~clk;

   clk_div_prog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_HALF(DEF)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .load    (load),
      .half_in (half_in),
      .div_clk (div_clk),
      .tick    (tick),
      .pend    (pend)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model: position within the current full period (low phase first).
   int m_h    [NUM_CH];
   int m_pv   [NUM_CH];
   int m_pos  [NUM_CH];
   bit m_pend [NUM_CH];

   int rises [NUM_CH][$];
   int falls [NUM_CH][$];
   logic [NUM_CH-1:0] prev_div = '0;

   typedef struct {
      bit          r;
      logic [1:0]  e;
      logic [1:0]  l;
      logic [15:0] h0;
      logic [15:0] h1;
      logic [1:0]  xd;
      logic [1:0]  xt;
      logic [1:0]  xp;
   } vec_t;

   vec_t tbl[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic int qget(input int ch, input bit is_rise, input int idx);
      if (is_rise) return (idx < rises[ch].size()) ? rises[ch][idx] : -1000;
      return (idx < falls[ch].size()) ? falls[ch][idx] : -1000;
   endfunction

   task automatic model_edge(input bit r, input logic [1:0] e, input logic [1:0] l,
                             input logic [15:0] h0, input logic [15:0] h1);
      for (int c = 0; c < NUM_CH; c++) begin
         int hin;
         hin = (c == 0) ? int'(h0) : int'(h1);
         if (r) begin
            m_h[c] = DEF; m_pv[c] = DEF; m_pend[c] = 1'b0; m_pos[c] = 0;
         end else if (!e[c]) begin
            m_pos[c] = 0;
            if (l[c]) begin
               m_h[c] = hin; m_pend[c] = 1'b0;
            end else if (m_pend[c]) begin
               m_h[c] = m_pv[c]; m_pend[c] = 1'b0;
            end
         end else begin
            m_pos[c] = (m_pos[c] + 1) % (2 * (m_h[c] + 1));
            if (m_pos[c] == 0) begin
               if (l[c]) begin
                  m_h[c] = hin; m_pend[c] = 1'b0;
               end else if (m_pend[c]) begin
                  m_h[c] = m_pv[c]; m_pend[c] = 1'b0;
               end
            end else if (l[c]) begin
               m_pv[c] = hin; m_pend[c] = 1'b1;
            end
         end
      end
   endtask

   task automatic step(input bit r, input logic [1:0] e, input logic [1:0] l,
                       input logic [15:0] h0, input logic [15:0] h1);
      rst = r; en = e; load = l; half_in = {h1, h0};
      @(posedge clk);
      #1;
      cyc++;
      model_edge(r, e, l, h0, h1);
      for (int c = 0; c < NUM_CH; c++) begin
         logic [2:0] exp_v, act_v;
         exp_v = {(m_pos[c] >= m_h[c] + 1), (m_pos[c] == m_h[c] + 1), m_pend[c]};
         act_v = {div_clk[c], tick[c], pend[c]};
         n_cmp++;
         if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL model ch%0d {div,tick,pend} @cyc %0d: got %b expected %b", c, cyc, act_v, exp_v);
         end
         if (prev_div[c] === 1'b0 && div_clk[c] === 1'b1) rises[c].push_back(cyc);
         if (prev_div[c] === 1'b1 && div_clk[c] === 1'b0) falls[c].push_back(cyc);
      end
      prev_div = div_clk;
   endtask

   task automatic run_until(input int ch, input bit is_rise, input int n, input int budget,
                            input logic [1:0] e, input string name);
      int k;
      k = 0;
      while (((is_rise ? rises[ch].size() : falls[ch].size()) < n) && k < budget) begin
         step(1'b0, e, 2'b00, 16'd0, 16'd0);
         k++;
      end
      check({name, " wait"}, ((is_rise ? rises[ch].size() : falls[ch].size()) >= n) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic clear_edges();
      for (int c = 0; c < NUM_CH; c++) begin
         rises[c].delete();
         falls[c].delete();
      end
   endtask

   initial begin
      int c0, ch1_act, tick_cnt, bad, first1;
      logic [15:0] h3;
      rst = 1'b1; en = '0; load = '0; half_in = '0;
      h3 = half_from_period(32'd8);

      // ---- table-driven vectors: reset, divide-by-2, pending apply ----
      tbl[0]  = '{1'b1, 2'b00, 2'b00, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00};
      tbl[1]  = '{1'b1, 2'b00, 2'b00, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00};
      tbl[2]  = '{1'b0, 2'b00, 2'b11, 16'd0, 16'd4, 2'b00, 2'b00, 2'b00};
      tbl[3]  = '{1'b0, 2'b01, 2'b00, 16'd0, 16'd0, 2'b01, 2'b01, 2'b00};
      tbl[4]  = '{1'b0, 2'b01, 2'b00, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00};
      tbl[5]  = '{1'b0, 2'b01, 2'b00, 16'd0, 16'd0, 2'b01, 2'b01, 2'b00};
      tbl[6]  = '{1'b0, 2'b01, 2'b00, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00};
      tbl[7]  = '{1'b0, 2'b01, 2'b01, h3,    16'd0, 2'b01, 2'b01, 2'b01};
      tbl[8]  = '{1'b0, 2'b01, 2'b00, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00};
      tbl[9]  = '{1'b0, 2'b01, 2'b00, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00};
      tbl[10] = '{1'b0, 2'b01, 2'b00, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00};
      tbl[11] = '{1'b0, 2'b01, 2'b00, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00};
      tbl[12] = '{1'b0, 2'b01, 2'b00, 16'd0, 16'd0, 2'b01, 2'b01, 2'b00};
      tbl[13] = '{1'b0, 2'b00, 2'b00, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00};
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].h0, tbl[i].h1);
         check($sformatf("vec%0d div", i),  {30'd0, div_clk}, {30'd0, tbl[i].xd});
         check($sformatf("vec%0d tick", i), {30'd0, tick},    {30'd0, tbl[i].xt});
         check($sformatf("vec%0d pend", i), {30'd0, pend},    {30'd0, tbl[i].xp});
      end

      // ---- reset default: period 50, 25 high, one tick per period, ch1 idle ----
      step(1'b1, 2'b01, 2'b00, 16'd0, 16'd0);
      step(1'b1, 2'b01, 2'b00, 16'd0, 16'd0);
      c0 = cyc;
      clear_edges();
      ch1_act = 0; tick_cnt = 0;
      for (int i = 0; i < 130; i++) begin
         step(1'b0, 2'b01, 2'b00, 16'd0, 16'd0);
         if (div_clk[1] !== 1'b0 || tick[1] !== 1'b0) ch1_act++;
         if (tick[0] === 1'b1) tick_cnt++;
      end
      check("default first rise", qget(0, 1'b1, 0) - c0, 32'd25);
      check("default period", qget(0, 1'b1, 1) - qget(0, 1'b1, 0), 32'd50);
      check("default high time", qget(0, 1'b0, 0) - qget(0, 1'b1, 0), 32'd25);
      check("default ticks", tick_cnt, 32'd3);
      check("ch1 idle", ch1_act, 32'd0);

      // ---- glitch-free change: load H=3 mid-high ----
      clear_edges();
      run_until(0, 1'b0, 1, 100, 2'b01, "glitch sync");
      for (int i = 0; i < 30; i++) step(1'b0, 2'b01, 2'b00, 16'd0, 16'd0);
      step(1'b0, 2'b01, 2'b01, 16'd3, 16'd0);
      check("glitch pend set", {31'd0, pend[0]}, 32'd1);
      run_until(0, 1'b0, 4, 200, 2'b01, "glitch falls");
      check("glitch old period", qget(0, 1'b0, 1) - qget(0, 1'b0, 0), 32'd50);
      check("glitch new period a", qget(0, 1'b0, 2) - qget(0, 1'b0, 1), 32'd8);
      check("glitch new period b", qget(0, 1'b0, 3) - qget(0, 1'b0, 2), 32'd8);

      // ---- load coinciding with the falling toggle ----
      clear_edges();
      run_until(0, 1'b0, 1, 20, 2'b01, "collide sync");
      for (int i = 0; i < 7; i++) step(1'b0, 2'b01, 2'b00, 16'd0, 16'd0);
      step(1'b0, 2'b01, 2'b01, 16'd9, 16'd0);
      check("collide fall seen", falls[0].size(), 32'd2);
      check("collide pend clear", {31'd0, pend[0]}, 32'd0);
      step(1'b0, 2'b01, 2'b01, 16'd5, 16'd0);
      check("collide second pend", {31'd0, pend[0]}, 32'd1);
      run_until(0, 1'b0, 4, 100, 2'b01, "collide falls");
      check("collide period 20", qget(0, 1'b0, 2) - qget(0, 1'b0, 1), 32'd20);
      check("collide period 12", qget(0, 1'b0, 3) - qget(0, 1'b0, 2), 32'd12);

      // ---- reset abort mid-high with counter at 10 ----
      step(1'b1, 2'b01, 2'b00, 16'd0, 16'd0);
      clear_edges();
      run_until(0, 1'b1, 1, 40, 2'b01, "abort rise");
      for (int i = 0; i < 10; i++) step(1'b0, 2'b01, 2'b00, 16'd0, 16'd0);
      check("abort pre div", {31'd0, div_clk[0]}, 32'd1);
      step(1'b1, 2'b01, 2'b00, 16'd0, 16'd0);
      check("abort div low", {31'd0, div_clk[0]}, 32'd0);
      c0 = cyc;
      clear_edges();
      run_until(0, 1'b1, 1, 40, 2'b01, "abort restart");
      check("abort first rise", qget(0, 1'b1, 0) - c0, 32'd25);

      // ---- channel independence ----
      step(1'b0, 2'b00, 2'b11, 16'd1, 16'd4);
      clear_edges();
      for (int i = 0; i < 20; i++) step(1'b0, 2'b11, 2'b00, 16'd0, 16'd0);
      for (int i = 0; i < 3; i++)  step(1'b0, 2'b01, 2'b00, 16'd0, 16'd0);
      c0 = cyc;
      for (int i = 0; i < 20; i++) step(1'b0, 2'b11, 2'b00, 16'd0, 16'd0);
      bad = 0;
      for (int i = 1; i < rises[0].size(); i++)
         if (rises[0][i] - rises[0][i-1] != 4) bad++;
      check("indep ch0 rises", rises[0].size(), 32'd11);
      check("indep ch0 period", bad, 32'd0);
      first1 = -1000;
      for (int i = rises[1].size() - 1; i >= 0; i--)
         if (rises[1][i] > c0) first1 = rises[1][i];
      check("indep ch1 restart", first1 - c0, 32'd5);

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 3000; i++) begin
         bit r;
         logic [1:0] e, l;
         logic [15:0] h0, h1;
         r = ($urandom_range(0, 199) == 0);
         e = {($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0)};
         l = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
         h0 = ($urandom_range(0, 31) == 0) ? 16'hFFFF : 16'($urandom_range(0, 12));
         h1 = ($urandom_range(0, 31) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
         step(r, e, l, h0, h1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
